de_pipe_reg: RTL and testbench
==============================

# de_pipe_reg

Decode/execute pipeline register with load-use hazard detection for the 64-bit RISC-V pipeline. It captures decoded operands, register indices and control bits from the decode stage each cycle and presents them as the `de_*` signals consumed by the execute stage and the forwarding unit (`de_rs1`, `de_rs2`). It detects load-use hazards that forwarding cannot cover, stalls the fetch/decode side, and inserts a bubble. It also flushes on branch redirect and holds on downstream stall.

## Interface
- XLEN, 64, datapath width
- CNT_W, 32, width of load-use stall counter
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous active-high reset
- fd_valid  input  1  decode slot holds a real instruction
- fd_pc  input  XLEN  instruction PC
- fd_rs1_data, fd_rs2_data  input  XLEN  register file read data
- fd_imm  input  XLEN  sign-extended immediate
- fd_rs1, fd_rs2, fd_rd  input  5  register indices
- fd_regWrite, fd_memRead, fd_memWrite, fd_memToReg, fd_aluSrc, fd_branch  input  1  decoded control
- fd_aluOp  input  4  ALU operation select
- ex_stall  input  1  downstream hold request (memory busy); freezes this register
- ex_flush  input  1  taken branch/jump resolved in EX; kill the decode-stage instruction
- de_valid, de_pc, de_rs1_data, de_rs2_data, de_imm, de_rs1, de_rs2, de_rd, de_regWrite, de_memRead, de_memWrite, de_memToReg, de_aluSrc, de_branch, de_aluOp  output  (widths as fd_*)  registered copies
- hazard_stall  output  1  combinational; holds PC and F/D register this cycle
- loaduse_count  output  CNT_W  number of bubbles inserted for load-use hazards

## Operation
- Load-use condition: `lu = de_valid & de_memRead & (de_rd != 0) & fd_valid & ((de_rd == fd_rs1) | (de_rd == fd_rs2))`.
- `hazard_stall = lu & ~ex_flush & ~ex_stall & ~rst`.
- Register update per rising edge, in priority order:
  1. rst: all `de_*` fields cleared to 0, loaduse_count = 0.
  2. ex_flush: bubble loaded.
  3. ex_stall: all `de_*` hold. loaduse_count holds.
  4. lu: bubble loaded. loaduse_count increments.
  5. Otherwise: every `de_*` field loaded from the matching `fd_*` field.
- Bubble: all `de_*` fields cleared to 0, including de_valid, de_rd and every control bit. An inserted bubble must never write the register file or memory.
- When fd_valid = 0, the slot loads normally (as a non-valid instruction), but all control bits are forced to 0.
- loaduse_count saturates at all-ones and does not wrap.
- Zero register: `de_rd = 0` never raises a hazard, even when de_memRead = 1.

## Timing
- Reset value of every output is 0, including hazard_stall while rst is high.
- Latency is 1 cycle, fd → de.
- One load-use hazard costs exactly one bubble cycle:
  - cycle N: lu = 1, so hazard_stall = 1 and a bubble is loaded at the N+1 edge.
  - cycle N+1: de_valid = 0, so lu = 0. The held consumer loads at the N+2 edge, and forwarding then supplies the load data from M/W.
- ex_flush and lu in the same cycle: flush wins. hazard_stall = 0 (the fetch redirect takes precedence) and the counter does not increment.
- ex_stall and lu in the same cycle: de holds and hazard_stall = 0. The upstream is held by the global stall, and the hazard is re-evaluated once ex_stall drops.
- ex_flush and ex_stall in the same cycle: flush wins and a bubble is loaded.
- rst asserted mid-stall: the next edge clears everything. The stall state is not retained.

## Test plan
- Reset, then rst=0 and fd_valid=1, fd_pc=0x1000, fd_rd=5, fd_regWrite=1 → next cycle de_pc=0x1000, de_rd=5, de_regWrite=1, de_valid=1. Before the first load, all outputs read 0 with rst=1.
- ld x7 in DE (de_memRead=1, de_rd=7) with fd_rs2=7 → hazard_stall=1 in the same cycle. Next cycle de_valid=0, de_regWrite=0, loaduse_count=1. The following cycle the consumer appears in DE with de_rs2=7.
- ld x0 in DE with fd_rs1=0 → hazard_stall=0, no bubble, loaduse_count unchanged.
- Load-use condition together with ex_flush=1 → hazard_stall=0, bubble loaded, loaduse_count unchanged. Same condition with ex_stall=1 → de_* unchanged and hazard_stall=0; dropping ex_stall then produces the bubble.
- With CNT_W=4, force 17 load-use bubbles → loaduse_count reads 15 (0xF) and stays there.
- Assert rst while hazard_stall=1 → next cycle all outputs 0 and loaduse_count=0.

Source files
------------

// File: rtl/de_pipe_reg.sv
// Decode/execute pipeline register: captures decoded fields each cycle, inserts
// a bubble on load-use hazards or branch flush, and holds on a downstream stall.
module de_pipe_reg #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             fd_valid,
    input  logic [XLEN-1:0]  fd_pc,
    input  logic [XLEN-1:0]  fd_rs1_data,
    input  logic [XLEN-1:0]  fd_rs2_data,
    input  logic [XLEN-1:0]  fd_imm,
    input  logic [4:0]       fd_rs1,
    input  logic [4:0]       fd_rs2,
    input  logic [4:0]       fd_rd,
    input  logic             fd_regWrite,
    input  logic             fd_memRead,
    input  logic             fd_memWrite,
    input  logic             fd_memToReg,
    input  logic             fd_aluSrc,
    input  logic             fd_branch,
    input  logic [3:0]       fd_aluOp,
    input  logic             ex_stall,
    input  logic             ex_flush,
    output logic             de_valid,
    output logic [XLEN-1:0]  de_pc,
    output logic [XLEN-1:0]  de_rs1_data,
    output logic [XLEN-1:0]  de_rs2_data,
    output logic [XLEN-1:0]  de_imm,
    output logic [4:0]       de_rs1,
    output logic [4:0]       de_rs2,
    output logic [4:0]       de_rd,
    output logic             de_regWrite,
    output logic             de_memRead,
    output logic             de_memWrite,
    output logic             de_memToReg,
    output logic             de_aluSrc,
    output logic             de_branch,
    output logic [3:0]       de_aluOp,
    output logic             hazard_stall,
    output logic [CNT_W-1:0] loaduse_count
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            regWrite;
        logic            memRead;
        logic            memWrite;
        logic            memToReg;
        logic            aluSrc;
        logic            branch;
        logic [3:0]      aluOp;
    } de_t;

    de_t              r_de;
    de_t              w_fd;
    logic [CNT_W-1:0] r_cnt;
    logic             w_lu;

    // A non-valid decode slot still loads, but can never write anything.
    always_comb begin
        w_fd          = '0;
        w_fd.valid    = fd_valid;
        w_fd.pc       = fd_pc;
        w_fd.rs1_data = fd_rs1_data;
        w_fd.rs2_data = fd_rs2_data;
        w_fd.imm      = fd_imm;
        w_fd.rs1      = fd_rs1;
        w_fd.rs2      = fd_rs2;
        w_fd.rd       = fd_rd;
        w_fd.regWrite = fd_valid & fd_regWrite;
        w_fd.memRead  = fd_valid & fd_memRead;
        w_fd.memWrite = fd_valid & fd_memWrite;
        w_fd.memToReg = fd_valid & fd_memToReg;
        w_fd.aluSrc   = fd_valid & fd_aluSrc;
        w_fd.branch   = fd_valid & fd_branch;
        w_fd.aluOp    = fd_valid ? fd_aluOp : 4'd0;
    end

    assign w_lu = r_de.valid & r_de.memRead & (r_de.rd != 5'd0) & fd_valid &
                  ((r_de.rd == fd_rs1) | (r_de.rd == fd_rs2));

    assign hazard_stall = w_lu & ~ex_flush & ~ex_stall & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_de  <= '0;
            r_cnt <= '0;
        end else if (ex_flush) begin
            r_de <= '0;
        end else if (!ex_stall) begin
            if (w_lu) begin
                r_de <= '0;
                if (r_cnt != {CNT_W{1'b1}})
                    r_cnt <= r_cnt + 1'b1;
            end else begin
                r_de <= w_fd;
            end
        end
    end

    assign de_valid      = r_de.valid;
    assign de_pc         = r_de.pc;
    assign de_rs1_data   = r_de.rs1_data;
    assign de_rs2_data   = r_de.rs2_data;
    assign de_imm        = r_de.imm;
    assign de_rs1        = r_de.rs1;
    assign de_rs2        = r_de.rs2;
    assign de_rd         = r_de.rd;
    assign de_regWrite   = r_de.regWrite;
    assign de_memRead    = r_de.memRead;
    assign de_memWrite   = r_de.memWrite;
    assign de_memToReg   = r_de.memToReg;
    assign de_aluSrc     = r_de.aluSrc;
    assign de_branch     = r_de.branch;
    assign de_aluOp      = r_de.aluOp;
    assign loaduse_count = r_cnt;

endmodule

// File: tb/tb_de_pipe_reg.sv
// Directed bench for de_pipe_reg: pass-through, load-use bubble, x0, flush/stall
// interactions, non-valid slot gating, counter saturation and reset mid-stall.
module tb_de_pipe_reg;
    localparam int XLEN  = 64;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             fd_valid;
    logic [XLEN-1:0]  fd_pc, fd_rs1_data, fd_rs2_data, fd_imm;
    logic [4:0]       fd_rs1, fd_rs2, fd_rd;
    logic             fd_regWrite, fd_memRead, fd_memWrite, fd_memToReg, fd_aluSrc, fd_branch;
    logic [3:0]       fd_aluOp;
    logic             ex_stall, ex_flush;
    logic             de_valid;
    logic [XLEN-1:0]  de_pc, de_rs1_data, de_rs2_data, de_imm;
    logic [4:0]       de_rs1, de_rs2, de_rd;
    logic             de_regWrite, de_memRead, de_memWrite, de_memToReg, de_aluSrc, de_branch;
    logic [3:0]       de_aluOp;
    logic             hazard_stall;
    logic [CNT_W-1:0] loaduse_count;

    int checks = 0;
    int errs   = 0;

    de_pipe_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .fd_valid(fd_valid), .fd_pc(fd_pc), .fd_rs1_data(fd_rs1_data),
        .fd_rs2_data(fd_rs2_data), .fd_imm(fd_imm),
        .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_rd(fd_rd),
        .fd_regWrite(fd_regWrite), .fd_memRead(fd_memRead), .fd_memWrite(fd_memWrite),
        .fd_memToReg(fd_memToReg), .fd_aluSrc(fd_aluSrc), .fd_branch(fd_branch),
        .fd_aluOp(fd_aluOp), .ex_stall(ex_stall), .ex_flush(ex_flush),
        .de_valid(de_valid), .de_pc(de_pc), .de_rs1_data(de_rs1_data),
        .de_rs2_data(de_rs2_data), .de_imm(de_imm),
        .de_rs1(de_rs1), .de_rs2(de_rs2), .de_rd(de_rd),
        .de_regWrite(de_regWrite), .de_memRead(de_memRead), .de_memWrite(de_memWrite),
        .de_memToReg(de_memToReg), .de_aluSrc(de_aluSrc), .de_branch(de_branch),
        .de_aluOp(de_aluOp), .hazard_stall(hazard_stall), .loaduse_count(loaduse_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_fd(input logic v, input logic [63:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd,
                          input logic rw, input logic mr);
        fd_valid    = v;
        fd_pc       = pc;
        fd_rs1_data = pc + 64'h11;
        fd_rs2_data = pc + 64'h22;
        fd_imm      = 64'hFFFF_FFFF_FFFF_FFF0;
        fd_rs1      = rs1;
        fd_rs2      = rs2;
        fd_rd       = rd;
        fd_regWrite = rw;
        fd_memRead  = mr;
        fd_memWrite = 1'b0;
        fd_memToReg = mr;
        fd_aluSrc   = 1'b1;
        fd_branch   = 1'b0;
        fd_aluOp    = 4'h3;
    endtask

    initial begin
        rst = 1'b1; ex_stall = 1'b0; ex_flush = 1'b0;
        set_fd(1'b1, 64'h500, 5'd1, 5'd2, 5'd9, 1'b1, 1'b1);
        tick; tick;
        chk("rst_valid", de_valid, 0);
        chk("rst_pc", de_pc, 0);
        chk("rst_rd", de_rd, 0);
        chk("rst_regwrite", de_regWrite, 0);
        chk("rst_memread", de_memRead, 0);
        chk("rst_count", loaduse_count, 0);
        chk("rst_hazard", hazard_stall, 0);

        // plain pass-through
        rst = 1'b0;
        set_fd(1'b1, 64'h1000, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0);
        tick;
        chk("pass_pc", de_pc, 64'h1000);
        chk("pass_rd", de_rd, 5);
        chk("pass_regwrite", de_regWrite, 1);
        chk("pass_valid", de_valid, 1);
        chk("pass_rs1data", de_rs1_data, 64'h1011);
        chk("pass_imm", de_imm, 64'hFFFF_FFFF_FFFF_FFF0);

        // ld x7 followed by consumer of x7 via rs2
        set_fd(1'b1, 64'h1004, 5'd3, 5'd4, 5'd7, 1'b1, 1'b1);
        #1 chk("ld_nohaz", hazard_stall, 0);
        tick;
        set_fd(1'b1, 64'h1008, 5'd1, 5'd7, 5'd8, 1'b1, 1'b0);
        #1 chk("lu_hazard", hazard_stall, 1);
        tick;
        chk("bub_valid", de_valid, 0);
        chk("bub_regwrite", de_regWrite, 0);
        chk("bub_pc", de_pc, 0);
        chk("bub_count", loaduse_count, 1);
        chk("bub_hazard_clear", hazard_stall, 0);
        tick;
        chk("cons_rs2", de_rs2, 7);
        chk("cons_pc", de_pc, 64'h1008);
        chk("cons_valid", de_valid, 1);

        // ld x0 never hazards
        set_fd(1'b1, 64'h100C, 5'd0, 5'd0, 5'd0, 1'b1, 1'b1);
        tick;
        set_fd(1'b1, 64'h1010, 5'd0, 5'd9, 5'd10, 1'b1, 1'b0);
        #1 chk("x0_hazard", hazard_stall, 0);
        tick;
        chk("x0_pc", de_pc, 64'h1010);
        chk("x0_count", loaduse_count, 1);

        // flush beats load-use
        set_fd(1'b1, 64'h1014, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        tick;
        set_fd(1'b1, 64'h1018, 5'd7, 5'd3, 5'd11, 1'b1, 0);
        ex_flush = 1'b1;
        #1 chk("flush_hazard", hazard_stall, 0);
        tick;
        ex_flush = 1'b0;
        chk("flush_valid", de_valid, 0);
        chk("flush_count", loaduse_count, 1);

        // stall holds, then hazard resolves after stall drops
        set_fd(1'b1, 64'h101C, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        tick;
        set_fd(1'b1, 64'h1020, 5'd7, 5'd3, 5'd12, 1'b1, 1'b0);
        ex_stall = 1'b1;
        #1 chk("stall_hazard", hazard_stall, 0);
        tick;
        chk("stall_pc", de_pc, 64'h101C);
        chk("stall_memread", de_memRead, 1);
        chk("stall_count", loaduse_count, 1);
        ex_stall = 1'b0;
        #1 chk("unstall_hazard", hazard_stall, 1);
        tick;
        chk("unstall_valid", de_valid, 0);
        chk("unstall_count", loaduse_count, 2);
        tick;
        chk("unstall_cons_pc", de_pc, 64'h1020);

        // flush + stall: flush wins
        ex_flush = 1'b1; ex_stall = 1'b1;
        tick;
        ex_flush = 1'b0; ex_stall = 1'b0;
        chk("flst_valid", de_valid, 0);
        chk("flst_pc", de_pc, 0);

        // non-valid slot loads with controls forced off
        set_fd(1'b0, 64'h2000, 5'd1, 5'd2, 5'd13, 1'b1, 1'b1);
        tick;
        chk("nv_valid", de_valid, 0);
        chk("nv_pc", de_pc, 64'h2000);
        chk("nv_regwrite", de_regWrite, 0);
        chk("nv_memread", de_memRead, 0);

        // 17 more bubbles from count 2 saturate a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            set_fd(1'b1, 64'h3000, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
            tick;
            set_fd(1'b1, 64'h3004, 5'd7, 5'd3, 5'd14, 1'b1, 1'b0);
            tick;
        end
        chk("sat_count", loaduse_count, 15);
        set_fd(1'b1, 64'h3000, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        tick;
        set_fd(1'b1, 64'h3004, 5'd7, 5'd3, 5'd14, 1'b1, 1'b0);
        tick;
        chk("sat_hold", loaduse_count, 15);

        // reset while stalling
        set_fd(1'b1, 64'h4000, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1);
        tick;
        set_fd(1'b1, 64'h4004, 5'd7, 5'd3, 5'd15, 1'b1, 1'b0);
        #1 chk("pre_rst_hazard", hazard_stall, 1);
        rst = 1'b1;
        #1 chk("rst_gate_hazard", hazard_stall, 0);
        tick;
        chk("mrst_valid", de_valid, 0);
        chk("mrst_pc", de_pc, 0);
        chk("mrst_memread", de_memRead, 0);
        chk("mrst_count", loaduse_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end
endmodule
